// File: rtl/balle_game_pkg.sv
// Shared definitions for the ball-game video/control slice.
// Holds the paddle motion FSM state encoding and the screen geometry
// constants that the paddle, ball and VGA stages all agree on.
package balle_game_pkg;

  localparam int unsigned SCREEN_W = 640;
  localparam int unsigned PADDLE_W = 64;

  // paddle_x as seen by the PIO, and the wider width used for the clamp
  // arithmetic so that subtraction/addition can never wrap.
  localparam int unsigned POS_W   = 11;
  localparam int unsigned ARITH_W = 12;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_MOVE_L = 2'd1,
    ST_MOVE_R = 2'd2
  } paddle_state_e;

endpackage

// File: rtl/button_debouncer.sv
// Synchronises one raw active-low push button into the clk domain and
// debounces it, producing a level "pressed" signal.
// Ports:
//   clk        system clock
//   reset_n    asynchronous active-low reset
//   i_btn_n    raw button, active-low, asynchronous to clk
//   o_pressed  accepted button state, 1 = pressed
module button_debouncer #(
  parameter int unsigned DEBOUNCE_CYCLES = 500000
) (
  input  logic clk,
  input  logic reset_n,
  input  logic i_btn_n,
  output logic o_pressed
);

  localparam int unsigned CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             r_sync1;
  logic             r_sync2;
  logic             r_pressed;
  logic [CNT_W-1:0] r_cnt;
  logic             w_sync_pressed;

  assign w_sync_pressed = ~r_sync2;
  assign o_pressed      = r_pressed;

  // The counter only runs while the synchronised input disagrees with the
  // accepted state; any agreeing sample restarts it, so a change is taken
  // only after DEBOUNCE_CYCLES consecutive disagreeing samples.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_sync1   <= 1'b1;
      r_sync2   <= 1'b1;
      r_pressed <= 1'b0;
      r_cnt     <= '0;
    end else begin
      r_sync1 <= i_btn_n;
      r_sync2 <= r_sync1;
      if (w_sync_pressed == r_pressed) begin
        r_cnt <= '0;
      end else if (r_cnt == CNT_LAST) begin
        r_pressed <= w_sync_pressed;
        r_cnt     <= '0;
      end else begin
        r_cnt <= r_cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: rtl/paddle_position_tracker.sv
// Paddle X coordinate for the ball game, read by the Nios through a PIO.
// Debounces the two paddle buttons, runs an IDLE/MOVE_L/MOVE_R FSM with a
// per-frame speed ramp, and updates the clamped position only on frame_tick
// so the PIO value is stable across a whole frame.
// Ports:
//   clk            system clock
//   reset_n        asynchronous active-low reset
//   btn_left_n     raw left button, active-low, asynchronous
//   btn_right_n    raw right button, active-low, asynchronous
//   frame_tick     one-cycle pulse at start of vertical blanking
//   paddle_x       current paddle X (registered)
//   at_left_edge   paddle_x == X_MIN (registered with paddle_x)
//   at_right_edge  paddle_x == X_MAX (registered with paddle_x)
module paddle_position_tracker
  import balle_game_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 500000,
  parameter int unsigned X_MIN           = 0,
  parameter int unsigned X_MAX           = SCREEN_W - PADDLE_W,
  parameter int unsigned X_RESET         = 288,
  parameter int unsigned SPEED_MIN       = 2,
  parameter int unsigned SPEED_MAX       = 8,
  parameter int unsigned RAMP_FRAMES     = 8
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             btn_left_n,
  input  logic             btn_right_n,
  input  logic             frame_tick,
  output logic [POS_W-1:0] paddle_x,
  output logic             at_left_edge,
  output logic             at_right_edge
);

  localparam int unsigned RAMP_W = (RAMP_FRAMES > 1) ? $clog2(RAMP_FRAMES) : 1;
  localparam logic [RAMP_W-1:0]  RAMP_LAST  = RAMP_W'(RAMP_FRAMES - 1);
  localparam logic [ARITH_W-1:0] SPD_MIN    = ARITH_W'(SPEED_MIN);
  localparam logic [ARITH_W-1:0] SPD_MAX    = ARITH_W'(SPEED_MAX);
  localparam logic [ARITH_W-1:0] XMIN_A     = ARITH_W'(X_MIN);
  localparam logic [ARITH_W-1:0] XMAX_A     = ARITH_W'(X_MAX);
  localparam logic [POS_W-1:0]   XMIN_P     = POS_W'(X_MIN);
  localparam logic [POS_W-1:0]   XMAX_P     = POS_W'(X_MAX);
  localparam logic [POS_W-1:0]   XRST_P     = POS_W'(X_RESET);

  logic               w_left;
  logic               w_right;
  paddle_state_e      r_state;
  paddle_state_e      w_next_state;
  logic [POS_W-1:0]   r_x;
  logic [POS_W-1:0]   w_x_next;
  logic               r_at_left;
  logic               r_at_right;
  logic [ARITH_W-1:0] r_speed;
  logic [RAMP_W-1:0]  r_ramp;
  logic [ARITH_W-1:0] w_x12;
  logic [ARITH_W-1:0] w_room_l;
  logic [ARITH_W-1:0] w_room_r;
  logic [ARITH_W-1:0] w_dec;
  logic [ARITH_W-1:0] w_inc;

  button_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb_left (
    .clk       (clk),
    .reset_n   (reset_n),
    .i_btn_n   (btn_left_n),
    .o_pressed (w_left)
  );

  button_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb_right (
    .clk       (clk),
    .reset_n   (reset_n),
    .i_btn_n   (btn_right_n),
    .o_pressed (w_right)
  );

  // Both buttons held cancel each other out.
  always_comb begin
    w_next_state = ST_IDLE;
    if (w_left && !w_right) begin
      w_next_state = ST_MOVE_L;
    end else if (w_right && !w_left) begin
      w_next_state = ST_MOVE_R;
    end
  end

  // Move uses the current (pre-transition) state and speed; the clamp
  // compares remaining room against speed so nothing ever wraps.
  always_comb begin
    w_x12    = {1'b0, r_x};
    w_room_l = w_x12 - XMIN_A;
    w_room_r = XMAX_A - w_x12;
    w_dec    = w_x12 - r_speed;
    w_inc    = w_x12 + r_speed;
    w_x_next = r_x;
    if (frame_tick) begin
      case (r_state)
        ST_MOVE_L: w_x_next = (w_room_l < r_speed) ? XMIN_P : w_dec[POS_W-1:0];
        ST_MOVE_R: w_x_next = (w_room_r < r_speed) ? XMAX_P : w_inc[POS_W-1:0];
        default:   w_x_next = r_x;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state    <= ST_IDLE;
      r_x        <= XRST_P;
      r_at_left  <= (XRST_P == XMIN_P);
      r_at_right <= (XRST_P == XMAX_P);
      r_speed    <= SPD_MIN;
      r_ramp     <= '0;
    end else begin
      r_state    <= w_next_state;
      r_x        <= w_x_next;
      r_at_left  <= (w_x_next == XMIN_P);
      r_at_right <= (w_x_next == XMAX_P);
      // A state change (including direct reversal) restarts the ramp and
      // overrides the tick update; IDLE keeps the ramp parked at reset.
      if ((w_next_state != r_state) || (w_next_state == ST_IDLE)) begin
        r_speed <= SPD_MIN;
        r_ramp  <= '0;
      end else if (frame_tick) begin
        if (r_ramp == RAMP_LAST) begin
          r_ramp <= '0;
          if (r_speed < SPD_MAX) begin
            r_speed <= r_speed + ARITH_W'(1);
          end
        end else begin
          r_ramp <= r_ramp + RAMP_W'(1);
        end
      end
    end
  end

  assign paddle_x      = r_x;
  assign at_left_edge  = r_at_left;
  assign at_right_edge = r_at_right;

endmodule

// File: tb/tb_paddle_position_tracker.sv
module tb_paddle_position_tracker;

  localparam int D    = 4;
  localparam int RF   = 2;
  localparam int XMIN = 0;
  localparam int XMAX = 576;
  localparam int XRST = 288;
  localparam int SMIN = 2;
  localparam int SMAX = 8;

  logic        clk;
  logic        reset_n;
  logic        btn_left_n;
  logic        btn_right_n;
  logic        frame_tick;
  logic [10:0] paddle_x;
  logic        at_left_edge;
  logic        at_right_edge;

  int n_checks = 0;
  int n_fail   = 0;

  paddle_position_tracker #(
    .DEBOUNCE_CYCLES (D),
    .X_MIN           (XMIN),
    .X_MAX           (XMAX),
    .X_RESET         (XRST),
    .SPEED_MIN       (SMIN),
    .SPEED_MAX       (SMAX),
    .RAMP_FRAMES     (RF)
  ) dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .btn_left_n    (btn_left_n),
    .btn_right_n   (btn_right_n),
    .frame_tick    (frame_tick),
    .paddle_x      (paddle_x),
    .at_left_edge  (at_left_edge),
    .at_right_edge (at_right_edge)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input int got, input int exp);
    n_checks++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, got, exp, $time);
    end
  endtask

  // Behavioural reference: a button is accepted once the last D
  // synchronised samples all disagree with the accepted value; speed is
  // derived from how many ticks have elapsed since entering the direction.
  int m_x;
  int m_dir;
  int m_ticks;
  bit m_acc_l;
  bit m_acc_r;
  bit hl [0:D];
  bit hr [0:D];

  always @(posedge clk or negedge reset_n) begin : model
    int spd;
    int nd;
    bit fl;
    bit fr;
    if (!reset_n) begin
      m_x = XRST; m_dir = 0; m_ticks = 0; m_acc_l = 0; m_acc_r = 0;
      for (int i = 0; i <= D; i++) begin hl[i] = 0; hr[i] = 0; end
    end else begin
      spd = SMIN + m_ticks / RF;
      if (spd > SMAX) spd = SMAX;
      if (frame_tick) begin
        if (m_dir < 0)      m_x = (m_x - XMIN < spd) ? XMIN : m_x - spd;
        else if (m_dir > 0) m_x = (XMAX - m_x < spd) ? XMAX : m_x + spd;
      end
      nd = (m_acc_l && !m_acc_r) ? -1 : ((m_acc_r && !m_acc_l) ? 1 : 0);
      if (nd != m_dir) m_ticks = 0;
      else if (frame_tick && m_dir != 0 && m_ticks < 1000) m_ticks++;
      m_dir = nd;
      fl = 1; fr = 1;
      for (int i = 1; i <= D; i++) begin
        if (hl[i] == m_acc_l) fl = 0;
        if (hr[i] == m_acc_r) fr = 0;
      end
      if (fl) m_acc_l = !m_acc_l;
      if (fr) m_acc_r = !m_acc_r;
      for (int i = D; i > 0; i--) begin hl[i] = hl[i-1]; hr[i] = hr[i-1]; end
      hl[0] = !btn_left_n;
      hr[0] = !btn_right_n;
    end
  end

  always @(negedge clk) begin
    if (reset_n === 1'b1) begin
      check("model_x", int'(paddle_x), m_x);
      check("model_left_edge", int'(at_left_edge), int'(m_x == XMIN));
      check("model_right_edge", int'(at_right_edge), int'(m_x == XMAX));
    end
  end

  task automatic wait_n(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic ticks(input int n);
    repeat (n) begin
      frame_tick = 1'b1;
      @(negedge clk);
      frame_tick = 1'b0;
      @(negedge clk);
    end
  endtask

  task automatic press(input bit l, input bit r);
    btn_left_n  = !l;
    btn_right_n = !r;
    wait_n(8);
  endtask

  task automatic release_all();
    btn_left_n  = 1'b1;
    btn_right_n = 1'b1;
    wait_n(8);
  endtask

  task automatic move(input bit left, input int n);
    press(left, !left);
    ticks(n);
    release_all();
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    wait_n(2);
    reset_n = 1'b1;
    wait_n(2);
  endtask

  int exp3 [14] = '{290, 292, 295, 298, 302, 306, 311, 316, 322, 328, 335, 342, 350, 358};

  initial begin
    reset_n     = 1'b0;
    btn_left_n  = 1'b1;
    btn_right_n = 1'b1;
    frame_tick  = 1'b0;
    wait_n(3);
    reset_n = 1'b1;
    wait_n(2);

    // 1: reset values, idle ticks
    check("t1_x", int'(paddle_x), 288);
    check("t1_left_edge", int'(at_left_edge), 0);
    check("t1_right_edge", int'(at_right_edge), 0);
    ticks(2);
    check("t1_idle_tick", int'(paddle_x), 288);

    // 2: 3-cycle glitch ignored; held press accepted after 6 cycles
    btn_left_n = 1'b0;
    wait_n(3);
    btn_left_n = 1'b1;
    wait_n(10);
    ticks(1);
    check("t2_glitch", int'(paddle_x), 288);
    btn_left_n = 1'b0;
    wait_n(6);
    frame_tick = 1'b1;     // sampled on the edge the FSM enters MOVE_L
    @(negedge clk);
    frame_tick = 1'b0;
    check("t2_tick_on_entry", int'(paddle_x), 288);
    ticks(1);
    check("t2_first_move", int'(paddle_x), 286);
    release_all();

    // 3: speed ramp to saturation
    do_reset();
    press(0, 1);
    for (int i = 0; i < 14; i++) begin
      ticks(1);
      check($sformatf("t3_x%0d", i), int'(paddle_x), exp3[i]);
    end
    release_all();

    // 4: left clamp
    do_reset();
    move(0, 3);
    check("t4_prep_295", int'(paddle_x), 295);
    move(1, 41);
    check("t4_prep_9", int'(paddle_x), 9);
    move(1, 2);
    move(1, 1);
    check("t4_prep_3", int'(paddle_x), 3);
    press(1, 0);
    ticks(1);
    check("t4_x1", int'(paddle_x), 1);
    check("t4_not_edge", int'(at_left_edge), 0);
    ticks(1);
    check("t4_x0", int'(paddle_x), 0);
    check("t4_left_edge", int'(at_left_edge), 1);
    ticks(2);
    check("t4_pinned", int'(paddle_x), 0);
    release_all();

    // 5: right clamp, then both buttons -> no motion
    move(0, 2);
    check("t5_prep_4", int'(paddle_x), 4);
    press(0, 1);
    ticks(76);
    check("t5_x570", int'(paddle_x), 570);
    check("t5_not_edge", int'(at_right_edge), 0);
    ticks(1);
    check("t5_x576", int'(paddle_x), 576);
    check("t5_right_edge", int'(at_right_edge), 1);
    btn_left_n = 1'b0;
    wait_n(8);
    ticks(2);
    check("t5_both_hold", int'(paddle_x), 576);
    release_all();

    // 6: async reset mid-ramp
    move(1, 1);
    check("t6_prep_574", int'(paddle_x), 574);
    press(1, 0);
    ticks(27);
    check("t6_x400", int'(paddle_x), 400);
    #2 reset_n = 1'b0;
    #1;
    check("t6_async_x", int'(paddle_x), 288);
    check("t6_async_ledge", int'(at_left_edge), 0);
    check("t6_async_redge", int'(at_right_edge), 0);
    @(negedge clk);
    btn_left_n = 1'b1;
    reset_n    = 1'b1;
    wait_n(8);
    move(0, 1);
    check("t6_first_speed", int'(paddle_x), 290);

    // random phase: short chatter first, then long holds reaching the edges
    for (int c = 0; c < 4000; c++) begin
      int rate;
      rate = (c < 2000) ? 15 : 199;
      if ($urandom_range(0, rate) == 0) btn_left_n  = ~btn_left_n;
      if ($urandom_range(0, rate) == 0) btn_right_n = ~btn_right_n;
      frame_tick = ($urandom_range(0, 3) == 0);
      reset_n    = ($urandom_range(0, 1999) != 0);
      @(negedge clk);
    end
    frame_tick = 1'b0;
    reset_n    = 1'b1;
    wait_n(2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
